// File: rtl/cape_gpio_pkg.sv
// Shared register map and encodings for the cape GPIO bank.
package cape_gpio_pkg;

    localparam logic [7:0] OFF_OUT      = 8'h00;
    localparam logic [7:0] OFF_OE       = 8'h04;
    localparam logic [7:0] OFF_IN       = 8'h08;
    localparam logic [7:0] OFF_SET      = 8'h0C;
    localparam logic [7:0] OFF_CLR      = 8'h10;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h14;
    localparam logic [7:0] OFF_IRQ_TYPE = 8'h18;
    localparam logic [7:0] OFF_IRQ_POL  = 8'h1C;
    localparam logic [7:0] OFF_IRQ_BOTH = 8'h20;
    localparam logic [7:0] OFF_STATUS   = 8'h24;
    localparam logic [7:0] OFF_ID       = 8'h28;

    localparam logic IRQ_LEVEL = 1'b0;
    localparam logic IRQ_EDGE  = 1'b1;

    localparam logic POL_HIGH_RISE = 1'b0;
    localparam logic POL_LOW_FALL  = 1'b1;

    localparam logic [31:0] ID_DEFAULT = 32'hCA9E_0100;

endpackage

// File: rtl/cape_gpio_sync.sv
// Pad input synchroniser with per-pin edge/level event detection.
module cape_gpio_sync
    import cape_gpio_pkg::*;
#(
    parameter int NUM_GPIO    = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_GPIO-1:0] gpio_i,
    input  logic [NUM_GPIO-1:0] type_i,
    input  logic [NUM_GPIO-1:0] pol_i,
    input  logic [NUM_GPIO-1:0] both_i,
    output logic [NUM_GPIO-1:0] in_sync_o,
    output logic [NUM_GPIO-1:0] event_o
);

    logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q, sync_d;
    logic [NUM_GPIO-1:0] prev_q;
    logic [NUM_GPIO-1:0] rise, fall, chg;

    always_comb begin
        sync_d = sync_q;
        sync_d[0] = gpio_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync_o = sync_q[SYNC_STAGES-1];

    assign rise = in_sync_o & ~prev_q;
    assign fall = ~in_sync_o & prev_q;
    assign chg  = in_sync_o ^ prev_q;

    always_comb begin
        event_o = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (type_i[i] == IRQ_EDGE) begin
                if (both_i[i]) begin
                    event_o[i] = chg[i];
                end else if (pol_i[i] == POL_LOW_FALL) begin
                    event_o[i] = fall[i];
                end else begin
                    event_o[i] = rise[i];
                end
            end else begin
                event_o[i] = in_sync_o[i] ^ pol_i[i];
            end
        end
    end

endmodule

// File: rtl/cape_gpio_apb.sv
// APB GPIO bank: output/direction registers, synced inputs, W1C irqs.
module cape_gpio_apb
    import cape_gpio_pkg::*;
#(
    parameter int          NUM_GPIO    = 28,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                APB_SLAVE_SLAVE_PSEL,
    input  logic                APB_SLAVE_SLAVE_PENABLE,
    input  logic                APB_SLAVE_SLAVE_PWRITE,
    input  logic [7:0]          APB_SLAVE_SLAVE_PADDR,
    input  logic [31:0]         APB_SLAVE_SLAVE_PWDATA,
    output logic [31:0]         APB_SLAVE_SLAVE_PRDATA,
    input  logic [NUM_GPIO-1:0] GPIO_IN,
    output logic [NUM_GPIO-1:0] GPIO_OUT,
    output logic [NUM_GPIO-1:0] GPIO_OE,
    output logic [NUM_GPIO-1:0] INT,
    output logic                INT_ANY
);

    logic [NUM_GPIO-1:0] out_q, out_d;
    logic [NUM_GPIO-1:0] oe_q, oe_d;
    logic [NUM_GPIO-1:0] en_q, en_d;
    logic [NUM_GPIO-1:0] type_q, type_d;
    logic [NUM_GPIO-1:0] pol_q, pol_d;
    logic [NUM_GPIO-1:0] both_q, both_d;
    logic [NUM_GPIO-1:0] status_q, status_d;

    logic [NUM_GPIO-1:0] in_sync, evt, wdata;
    logic [7:0]          addr;
    logic                wr_en, rd_en;
    logic                unused_bits;

    assign addr  = {APB_SLAVE_SLAVE_PADDR[7:2], 2'b00};
    assign wdata = APB_SLAVE_SLAVE_PWDATA[NUM_GPIO-1:0];
    assign wr_en = APB_SLAVE_SLAVE_PSEL & APB_SLAVE_SLAVE_PENABLE &
                   APB_SLAVE_SLAVE_PWRITE;
    assign rd_en = APB_SLAVE_SLAVE_PSEL & ~APB_SLAVE_SLAVE_PWRITE;

    assign unused_bits = ^{APB_SLAVE_SLAVE_PADDR[1:0], APB_SLAVE_SLAVE_PWDATA};

    cape_gpio_sync #(
        .NUM_GPIO    (NUM_GPIO),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .gpio_i    (GPIO_IN),
        .type_i    (type_q),
        .pol_i     (pol_q),
        .both_i    (both_q),
        .in_sync_o (in_sync),
        .event_o   (evt)
    );

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        en_d     = en_q;
        type_d   = type_q;
        pol_d    = pol_q;
        both_d   = both_q;
        status_d = status_q | evt;
        if (wr_en) begin
            unique case (addr)
                OFF_OUT:      out_d  = wdata;
                OFF_OE:       oe_d   = wdata;
                OFF_SET:      out_d  = out_q | wdata;
                OFF_CLR:      out_d  = out_q & ~wdata;
                OFF_IRQ_EN:   en_d   = wdata;
                OFF_IRQ_TYPE: type_d = wdata;
                OFF_IRQ_POL:  pol_d  = wdata;
                OFF_IRQ_BOTH: both_d = wdata;
                // A same-cycle event outranks the clear
                OFF_STATUS:   status_d = (status_q & ~wdata) | evt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            out_q    <= '0;
            oe_q     <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            both_q   <= '0;
            status_q <= '0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            en_q     <= en_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            both_q   <= both_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        APB_SLAVE_SLAVE_PRDATA = '0;
        if (rd_en) begin
            unique case (addr)
                OFF_OUT:      APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = out_q;
                OFF_OE:       APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = oe_q;
                OFF_IN:       APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = in_sync;
                OFF_IRQ_EN:   APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = en_q;
                OFF_IRQ_TYPE: APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = type_q;
                OFF_IRQ_POL:  APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = pol_q;
                OFF_IRQ_BOTH: APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = both_q;
                OFF_STATUS:   APB_SLAVE_SLAVE_PRDATA[NUM_GPIO-1:0] = status_q;
                OFF_ID:       APB_SLAVE_SLAVE_PRDATA = ID_VALUE;
                default: ;
            endcase
        end
    end

    assign GPIO_OUT = out_q;
    assign GPIO_OE  = oe_q;
    assign INT      = status_q & en_q;
    assign INT_ANY  = |INT;

endmodule

// File: tb/tb_cape_gpio_apb.sv
// Directed scoreboard bench for the cape GPIO APB bank.
module tb_cape_gpio_apb;

    localparam int N = 28;
    localparam logic [31:0] ID = 32'hCA9E_0100;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL, PENABLE, PWRITE;
    logic [7:0]    PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic [N-1:0]  GPIO_IN, GPIO_OUT, GPIO_OE, INT;
    logic          INT_ANY;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 PCLK = ~PCLK;

    cape_gpio_apb #(
        .NUM_GPIO    (N),
        .SYNC_STAGES (2),
        .ID_VALUE    (ID)
    ) dut (
        .PCLK                    (PCLK),
        .PRESET                  (PRESET),
        .APB_SLAVE_SLAVE_PSEL    (PSEL),
        .APB_SLAVE_SLAVE_PENABLE (PENABLE),
        .APB_SLAVE_SLAVE_PWRITE  (PWRITE),
        .APB_SLAVE_SLAVE_PADDR   (PADDR),
        .APB_SLAVE_SLAVE_PWDATA  (PWDATA),
        .APB_SLAVE_SLAVE_PRDATA  (PRDATA),
        .GPIO_IN                 (GPIO_IN),
        .GPIO_OUT                (GPIO_OUT),
        .GPIO_OE                 (GPIO_OE),
        .INT                     (INT),
        .INT_ANY                 (INT_ANY)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, e);
        end
    endtask

    // Entered and left 1 time unit after a rising edge; commit on 2nd edge.
    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK); d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a,
                            input logic [31:0] e);
        logic [31:0] d;
        expect_val(tag, e);
        apb_rd(a, d);
        compare(d);
    endtask

    task automatic sig_check(input string tag, input logic [31:0] obs,
                             input logic [31:0] e);
        expect_val(tag, e);
        compare(obs);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; GPIO_IN = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Reset values across the whole map
        sig_check("rst_gpio_oe", 32'(GPIO_OE), 32'h0);
        sig_check("rst_gpio_out", 32'(GPIO_OUT), 32'h0);
        sig_check("rst_int_any", 32'(INT_ANY), 32'h0);
        sig_check("rst_prdata_idle", PRDATA, 32'h0);
        for (int a = 0; a <= 8'h2C; a += 4) begin
            rd_check($sformatf("rst_rd_%02h", a), 8'(a),
                     (a == 8'h28) ? ID : 32'h0);
        end

        // OUT / SET / CLR / OE
        apb_wr(8'h00, 32'h0000_00F0);
        sig_check("gpio_out_wr", 32'(GPIO_OUT), 32'h0000_00F0);
        apb_wr(8'h0C, 32'h0000_000F);
        sig_check("gpio_out_set", 32'(GPIO_OUT), 32'h0000_00FF);
        apb_wr(8'h10, 32'h0000_0030);
        sig_check("gpio_out_clr", 32'(GPIO_OUT), 32'h0000_00CF);
        apb_wr(8'h04, 32'h0FFF_FFFF);
        sig_check("gpio_oe_wr", 32'(GPIO_OE), 32'h0FFF_FFFF);
        rd_check("out_rd", 8'h00, 32'h0000_00CF);
        rd_check("set_rd_zero", 8'h0C, 32'h0);
        rd_check("clr_rd_zero", 8'h10, 32'h0);
        apb_wr(8'h00, 32'hFFFF_FFFF);
        rd_check("out_rd_mask", 8'h00, 32'h0FFF_FFFF);
        apb_wr(8'h30, 32'hFFFF_FFFF);
        rd_check("unmapped_rd", 8'h30, 32'h0);

        // Pin 5 rising edge latency
        apb_wr(8'h18, 32'h0000_0020);
        apb_wr(8'h14, 32'h0000_0020);
        GPIO_IN[5] = 1'b1;
        @(posedge PCLK); @(posedge PCLK); #1;
        sig_check("p5_int_early", 32'(INT), 32'h0);
        @(posedge PCLK); #1;
        sig_check("p5_int_on_time", 32'(INT), 32'h0000_0020);
        rd_check("p5_status", 8'h24, 32'h0000_0020);
        rd_check("p5_in", 8'h08, 32'h0000_0020);
        apb_wr(8'h24, 32'h0000_0020);
        sig_check("p5_w1c_int_any", 32'(INT_ANY), 32'h0);
        GPIO_IN[5] = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        rd_check("p5_fall_no_set", 8'h24, 32'h0);

        // Pin 2 level-low keeps re-setting while held
        apb_wr(8'h1C, 32'h0000_0004);
        repeat (3) @(posedge PCLK);
        #1;
        rd_check("p2_level_set", 8'h24, 32'h0000_0004);
        apb_wr(8'h24, 32'h0000_0004);
        rd_check("p2_level_resets", 8'h24, 32'h0000_0004);
        sig_check("p2_masked_int_any", 32'(INT_ANY), 32'h0);
        GPIO_IN[2] = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        apb_wr(8'h24, 32'h0000_0004);
        rd_check("p2_released_clear", 8'h24, 32'h0);

        // Pin 7 both-edges, masked then enabled, set beats W1C
        apb_wr(8'h18, 32'h0000_00A0);
        apb_wr(8'h20, 32'h0000_0080);
        GPIO_IN[7] = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        rd_check("p7_status_masked", 8'h24, 32'h0000_0080);
        sig_check("p7_int_masked", 32'(INT), 32'h0);
        apb_wr(8'h14, 32'h0000_00A0);
        sig_check("p7_int_enabled", 32'(INT), 32'h0000_0080);
        sig_check("p7_int_any", 32'(INT_ANY), 32'h1);
        GPIO_IN[7] = 1'b0;
        @(posedge PCLK); #1;
        apb_wr(8'h24, 32'h0000_0080);
        rd_check("p7_set_beats_w1c", 8'h24, 32'h0000_0080);

        // Reset during an OE write with pending status
        GPIO_IN = '0;
        repeat (4) @(posedge PCLK);
        #1;
        rd_check("pre_rst_status", 8'h24, 32'h0000_0084);
        sig_check("pre_rst_int_any", 32'(INT_ANY), 32'h1);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h04;
        PWDATA = 32'h0000_0005; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
        sig_check("mid_rst_gpio_oe", 32'(GPIO_OE), 32'h0);
        sig_check("mid_rst_gpio_out", 32'(GPIO_OUT), 32'h0);
        sig_check("mid_rst_int", 32'(INT), 32'h0);
        sig_check("mid_rst_int_any", 32'(INT_ANY), 32'h0);
        rd_check("mid_rst_oe_rd", 8'h04, 32'h0);
        rd_check("mid_rst_status", 8'h24, 32'h0);
        rd_check("mid_rst_id", 8'h28, ID);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0",
                   exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
